// File: rtl/incubator_pkg.sv
// Shared types and constants for the incubator probe scheduler.
// Range limits are only consulted when SENS_RANGE_CHECK_EN is defined.
package incubator_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        NEXT,
        AVG
    } state_t;

    localparam int TEMP_W         = 8;
    localparam int TEMP_RESET_DEF = 25;
    localparam int RANGE_MIN      = -40;
    localparam int RANGE_MAX      = 85;

endpackage

// File: rtl/incubator_tick_counter.sv
// Saturating up-counter with synchronous clear and terminal-count flag.
// Holds at TERM until cleared.
module incubator_tick_counter #(
    parameter int          WIDTH = 8,
    parameter int unsigned TERM  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign tc = (cnt_q == WIDTH'(TERM));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !tc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/incubator_sensor_scheduler.sv
// Polls N_SENS probes in turn, averages the readings, flags silent probes.
// Define SENS_RANGE_CHECK_EN to reject acknowledged samples outside [-40, 85].
module incubator_sensor_scheduler
    import incubator_pkg::*;
#(
    parameter int N_SENS     = 4,
    parameter int PERIOD     = 100,
    parameter int TIMEOUT    = 15,
    parameter int TEMP_RESET = TEMP_RESET_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic [N_SENS-1:0] sens_req,
    input  logic [N_SENS-1:0] sens_ack,
    input  logic [7:0]        sens_data,
    output logic [7:0]        temp_out,
    output logic              temp_valid,
    output logic [N_SENS-1:0] fault,
    output logic              alarm
);

    localparam int IDX_W = $clog2(N_SENS);
    localparam int ACC_W = TEMP_W + IDX_W;
    localparam int PER_W = $clog2(PERIOD) + 1;
    localparam int TO_W  = $clog2(TIMEOUT) + 1;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      resp_q, resp_d;
    logic [N_SENS-1:0]         req_q, req_d;
    logic signed [TEMP_W-1:0]  temp_q, temp_d;
    logic                      valid_q, valid_d;
    logic [N_SENS-1:0]         fault_q, fault_d;
    logic                      alarm_q, alarm_d;

    logic per_tc;
    logic to_tc;
    logic ack_sel;
    logic data_ok;
    logic signed [TEMP_W-1:0] sample;

    incubator_tick_counter #(
        .WIDTH (PER_W),
        .TERM  (PERIOD - 1)
    ) u_period (
        .clk (clk),
        .rst (rst),
        .clr (state_q == IDLE && per_tc),
        .en  (state_q == IDLE),
        .tc  (per_tc)
    );

    incubator_tick_counter #(
        .WIDTH (TO_W),
        .TERM  (TIMEOUT - 1)
    ) u_timeout (
        .clk (clk),
        .rst (rst),
        .clr (state_q == REQ),
        .en  (state_q == WAIT),
        .tc  (to_tc)
    );

    assign sample  = $signed(sens_data);
    assign ack_sel = sens_ack[idx_q];

`ifdef SENS_RANGE_CHECK_EN
    assign data_ok = (sample >= RANGE_MIN) && (sample <= RANGE_MAX);
`else
    assign data_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        resp_d  = resp_q;
        req_d   = req_q;
        temp_d  = temp_q;
        valid_d = 1'b0;
        fault_d = fault_q;
        alarm_d = alarm_q;
        unique case (state_q)
            IDLE: begin
                if (per_tc) begin
                    state_d = REQ;
                    idx_d   = '0;
                    acc_d   = '0;
                    resp_d  = 1'b0;
                    req_d   = N_SENS'(1);
                end
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                // A rejected sample falls through to the substitute path.
                if (ack_sel && data_ok) begin
                    acc_d          = acc_q + ACC_W'(sample);
                    resp_d         = 1'b1;
                    fault_d[idx_q] = 1'b0;
                    req_d          = '0;
                    state_d        = NEXT;
                end else if (ack_sel || to_tc) begin
                    acc_d          = acc_q + ACC_W'(temp_q);
                    fault_d[idx_q] = 1'b1;
                    req_d          = '0;
                    state_d        = NEXT;
                end
            end
            NEXT: begin
                if (idx_q == IDX_W'(N_SENS - 1)) begin
                    state_d = AVG;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    req_d   = N_SENS'(1) << idx_d;
                    state_d = REQ;
                end
            end
            AVG: begin
                if (resp_q) begin
                    temp_d  = TEMP_W'(acc_q >>> IDX_W);
                    valid_d = 1'b1;
                    alarm_d = 1'b0;
                end else begin
                    alarm_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            resp_q  <= 1'b0;
            req_q   <= '0;
            temp_q  <= TEMP_W'(TEMP_RESET);
            valid_q <= 1'b0;
            fault_q <= '0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            resp_q  <= resp_d;
            req_q   <= req_d;
            temp_q  <= temp_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            alarm_q <= alarm_d;
        end
    end

    assign sens_req   = req_q;
    assign temp_out   = temp_q;
    assign temp_valid = valid_q;
    assign fault      = fault_q;
    assign alarm      = alarm_q;

endmodule

// File: tb/tb_incubator_sensor_scheduler.sv
// Directed scoreboard bench for incubator_sensor_scheduler.
// A probe responder answers requests; expected scan results are queued.
module tb_incubator_sensor_scheduler;

    localparam int N   = 4;
    localparam int PER = 20;
    localparam int TO  = 6;
    localparam int TR  = 25;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] sens_req;
    logic [N-1:0] sens_ack;
    logic [7:0]   sens_data;
    logic [7:0]   temp_out;
    logic         temp_valid;
    logic [N-1:0] fault;
    logic         alarm;

    always #5 clk = ~clk;

    incubator_sensor_scheduler #(
        .N_SENS     (N),
        .PERIOD     (PER),
        .TIMEOUT    (TO),
        .TEMP_RESET (TR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sens_req   (sens_req),
        .sens_ack   (sens_ack),
        .sens_data  (sens_data),
        .temp_out   (temp_out),
        .temp_valid (temp_valid),
        .fault      (fault),
        .alarm      (alarm)
    );

    typedef struct {
        int           temp;
        bit           valid;
        logic [N-1:0] flt;
        bit           alm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pdata[N];
    bit   presp[N];
    int   pdelay = 1;
    bit   noise  = 1'b0;
    int   wcnt[N];
    int   model_temp = TR;

    // Probe responder: acks the selected probe pdelay cycles into its request.
    initial begin : responder
        sens_ack  = '0;
        sens_data = '0;
        forever begin
            @(negedge clk);
            sens_ack  = '0;
            sens_data = 8'($urandom);
            for (int i = 0; i < N; i++) begin
                if (sens_req[i]) begin
                    if (presp[i] && wcnt[i] == pdelay) begin
                        sens_ack[i] = 1'b1;
                        sens_data   = 8'(pdata[i]);
                    end
                    wcnt[i]++;
                end else begin
                    wcnt[i] = 0;
                end
            end
            if (noise) sens_ack = sens_ack | ~sens_req;
        end
    end

    task automatic check(input string tag,
                         input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic scan_cfg(input int d0, input int d1, input int d2,
                            input int d3, input logic [N-1:0] resp,
                            input int dly);
        exp_t e;
        int   sum;
        bit   any;
        bit   ok;
        pdata[0] = d0;
        pdata[1] = d1;
        pdata[2] = d2;
        pdata[3] = d3;
        pdelay   = dly;
        sum      = 0;
        any      = 1'b0;
        for (int i = 0; i < N; i++) begin
            presp[i] = resp[i] && (dly <= TO);
            ok       = presp[i];
`ifdef SENS_RANGE_CHECK_EN
            if (pdata[i] < -40 || pdata[i] > 85) ok = 1'b0;
`endif
            if (ok) begin
                sum      += pdata[i];
                e.flt[i] = 1'b0;
                any      = 1'b1;
            end else begin
                sum      += model_temp;
                e.flt[i] = 1'b1;
            end
        end
        if (any) model_temp = sum >>> $clog2(N);
        e.temp  = model_temp;
        e.valid = any;
        e.alm   = !any;
        sb.push_back(e);
    endtask

    task automatic wait_scan(input string tag);
        int   n;
        bit   seen;
        exp_t e;
        n    = 0;
        seen = 1'b0;
        while (!(seen && sens_req == '0) && n < 1000) begin
            @(negedge clk);
            n++;
            if (sens_req[N-1]) seen = 1'b1;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $error("FAIL %s_scan_timeout: observed %0d expected <1000", tag, n);
        end
        repeat (2) @(negedge clk);
        e = sb.pop_front();
        check({tag, "_temp"},  $signed(temp_out), e.temp);
        check({tag, "_valid"}, temp_valid, e.valid);
        check({tag, "_fault"}, fault, e.flt);
        check({tag, "_alarm"}, alarm, e.alm);
        @(negedge clk);
        check({tag, "_pulse"}, temp_valid, 0);
    endtask

    initial begin : stim
        int  n;
        bit  saw_valid;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_req",   sens_req, 0);
        check("rst_temp",  $signed(temp_out), TR);
        check("rst_valid", temp_valid, 0);
        check("rst_fault", fault, 0);
        check("rst_alarm", alarm, 0);

        scan_cfg(20, 22, 24, 26, 4'b1111, 2);
        wait_scan("s1_avg");
        scan_cfg(-3, -4, -4, -4, 4'b1111, 1);
        wait_scan("s2_floor");
        scan_cfg(30, 30, 30, 30, 4'b1011, 1);
        wait_scan("s3_timeout");
        scan_cfg(24, 24, 24, 24, 4'b1111, TO);
        wait_scan("s4_ack_at_tc");
        scan_cfg(0, 0, 0, 0, 4'b0000, 1);
        wait_scan("s5_all_fail");
        noise = 1'b1;
        scan_cfg(10, 12, 14, 16, 4'b1111, 1);
        wait_scan("s6_noise");
        noise = 1'b0;
        scan_cfg(8, 8, 8, 8, 4'b1111, TO + 1);
        wait_scan("s7_late_ack");

        scan_cfg(40, 40, 40, 40, 4'b1101, 1);
        void'(sb.pop_back());
        n = 0;
        while (sens_req != 4'b0010 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("mid_wait_seen", sens_req, 4'b0010);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_temp = TR;
        check("mid_rst_req",   sens_req, 0);
        check("mid_rst_temp",  $signed(temp_out), TR);
        check("mid_rst_fault", fault, 0);
        check("mid_rst_alarm", alarm, 0);
        check("mid_rst_valid", temp_valid, 0);
        scan_cfg(100, 20, 20, 20, 4'b1111, 1);
        n         = 0;
        saw_valid = 1'b0;
        while (sens_req == '0 && n < 500) begin
            @(negedge clk);
            n++;
            if (temp_valid) saw_valid = 1'b1;
        end
        check("restart_delay", n, PER);
        check("no_valid_after_rst", saw_valid, 0);
        wait_scan("s8_range");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/incubator_sensor_scheduler.md
Name: incubator_sensor_scheduler

Overview:
Polls N_SENS temperature probes over a shared request/acknowledge bus on a fixed schedule. Averages the probe readings and presents one validated signed temperature to the incubator control FSM. Detects and flags non-responding probes. Sits between the probe interface logic and the incubator heater/cooler/fan controller.

Parameters:
N_SENS, 4, number of probes; must be a power of 2, range 2..8
PERIOD, 100, idle clock cycles between the end of one scan and the start of the next; must be >= 1
TIMEOUT, 15, maximum cycles to wait for an acknowledge per probe; must be >= 1
TEMP_RESET, 25, value of temp_out after reset (signed degrees C)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
sens_req  out  N_SENS  one-hot read request, one bit per probe
sens_ack  in  N_SENS  per-probe acknowledge; sens_data is valid in a cycle where the selected probe's bit is high
sens_data  in  8  signed probe reading, shared bus
temp_out  out  8  signed averaged temperature, held between updates
temp_valid  out  1  one-cycle pulse when temp_out updates
fault  out  N_SENS  per-probe fault flags
alarm  out  1  high while every probe faulted in the last scan

Behaviour:
- Reset, sampled on clk: state IDLE; sens_req=0; temp_out=TEMP_RESET; temp_valid=0; fault=0; alarm=0; period counter=0; accumulator=0.
- States:
  - IDLE: period counter increments each cycle. When it reaches PERIOD-1, clear the counter, clear the accumulator, set index=0, and go to REQ.
  - REQ (1 cycle): drive sens_req = 1<<index. Clear the timeout counter. Go to WAIT.
  - WAIT: hold sens_req.
    - If sens_ack[index]=1: add sens_data (sign-extended) to the accumulator, clear fault[index], go to NEXT.
    - Else if the timeout counter reaches TIMEOUT-1: add the current temp_out to the accumulator as a substitute, set fault[index], go to NEXT.
    - Otherwise increment the timeout counter.
  - NEXT: sens_req=0. If index==N_SENS-1 go to AVG; else increment index and go to REQ.
  - AVG (1 cycle):
    - If at least one probe responded in this scan: temp_out = accumulator >>> log2(N_SENS) (arithmetic shift, rounds toward minus infinity), pulse temp_valid, alarm=0.
    - If every probe timed out: temp_out is held, no temp_valid pulse, alarm=1.
    - Go to IDLE.
- Accumulator width is 8+log2(N_SENS) bits, signed, so it cannot overflow.
- Ack and timeout in the same cycle: the ack wins.
- Ack bits for non-selected probes, and any ack outside WAIT, are ignored.
- Exactly one sens_req bit is high in REQ/WAIT; none in any other state.
- Minimum scan latency: 3 cycles per probe (REQ, WAIT with ack, NEXT) plus 1 for AVG.
- fault bits are sticky until that probe acks in a later scan.
- rst asserted mid-scan: all outputs return to reset values on the next edge, the partial scan is discarded, and no temp_valid is produced.

Optional Feature:
SENS_RANGE_CHECK_EN
- Defined: an acknowledged sample outside [-40, 85] is treated exactly like a timeout. The probe is marked faulted, temp_out is substituted into the accumulator, and the sample is not counted as a response.
- Undefined: every acknowledged sample is accepted unchanged.

Decomposition:
- Package incubator_pkg: state enum (IDLE, REQ, WAIT, NEXT, AVG), TEMP_W=8, TEMP_RESET default, range limits RANGE_MIN=-40 and RANGE_MAX=85.
- One sub-module, incubator_tick_counter: a generic saturating up-counter with clear and terminal-count output. It is instantiated twice, once for the period and once for the timeout.

Test Plan:
1. N_SENS=4, all probes ack after 2 cycles with 20, 22, 24, 26 -> temp_out=23, one temp_valid pulse, fault=0, alarm=0.
2. Readings -3, -4, -4, -4 -> sum -15 >>> 2 = -4; temp_out=-4 (check floor rounding).
3. Probe 2 never acks, others 30, 30, 30, previous temp_out=26 -> after TIMEOUT cycles fault=4'b0100; temp_out=(90+26)>>>2=29. Next scan probe 2 acks -> fault=0.
4. No probe acks -> alarm=1, temp_out held at 25, no temp_valid. Next scan with acks -> alarm=0.
5. rst pulsed while waiting on probe 1 -> next cycle sens_req=0, temp_out=25, fault=0; a new scan starts PERIOD cycles later.
6. With SENS_RANGE_CHECK_EN, probe 0 returns 100, others 20, temp_out=20 -> fault[0]=1, temp_out=20. Without the macro -> temp_out=40, fault=0.
